// File: rtl/vram_responder.sv
// RAM-port responder for the vector load/store unit: zero-fills after reset,
// then serves byte-masked writes and fixed-latency reads from a local array.
module vram_responder #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 14,
   parameter int DATA_W = 256,
   parameter int RD_LAT = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   output logic                ready,
   input  logic                wren,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W/8-1:0] byteena,
   input  logic [DATA_W-1:0]   writeData,
   output logic [DATA_W-1:0]   readData,
   output logic                rvalid,
   output logic                init_done,
   output logic                err
);
   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY} state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  init_cnt;
   logic [2:0]        lat_cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_buf;
   logic [DATA_W-1:0] rd_word;
   logic [IDX_W-1:0]  idx;
   logic              in_range;
   logic              accept;

   // Compare the full address so upper bits never alias onto stored words
   assign in_range = address < ADDR_W'(DEPTH);
   assign idx      = address[IDX_W-1:0];
   assign accept   = req && ready;
   assign rd_word  = in_range ? mem[idx] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_INIT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      init_done = 1'b1;
      case (state)
         S_INIT: begin
            init_done = 1'b0;
            if (init_cnt == IDX_W'(DEPTH - 1)) state_nxt = S_IDLE;
         end
         S_IDLE: begin
            ready = 1'b1;
            if (req && !wren && RD_LAT > 1) state_nxt = S_BUSY;
         end
         S_BUSY: begin
            if (lat_cnt == 3'd1) state_nxt = S_IDLE;
         end
         default: state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         init_cnt <= '0;
         lat_cnt  <= '0;
         rd_buf   <= '0;
         readData <= '0;
         rvalid   <= 1'b0;
         err      <= 1'b0;
      end else begin
         rvalid <= 1'b0;
         err    <= 1'b0;
         if (state == S_INIT) init_cnt <= init_cnt + IDX_W'(1);
         if (accept) begin
            err <= !in_range;
            if (!wren) begin
               if (RD_LAT == 1) begin
                  rvalid   <= 1'b1;
                  readData <= rd_word;
               end else begin
                  rd_buf  <= rd_word;
                  lat_cnt <= 3'(RD_LAT - 1);
               end
            end
         end
         // BUSY counts down the remaining latency; the last step fires the response
         if (state == S_BUSY) begin
            lat_cnt <= lat_cnt - 3'd1;
            if (lat_cnt == 3'd1) begin
               rvalid   <= 1'b1;
               readData <= rd_buf;
            end
         end
      end
   end

   // Storage has no reset; INIT owns the write port until the fill completes
   always_ff @(posedge clk) begin
      if (state == S_INIT) begin
         mem[init_cnt] <= '0;
      end else if (accept && wren && in_range) begin
         for (int i = 0; i < BE_W; i++)
            if (byteena[i]) mem[idx][8*i +: 8] <= writeData[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_vram_responder.sv
// Randomized bench for vram_responder against a word-array reference model.
module tb_vram_responder;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 256;
   localparam int RD_LAT = 2;
   localparam int BE_W   = DATA_W / 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req = 1'b0;
   logic              wren = 1'b0;
   logic [ADDR_W-1:0] address = '0;
   logic [BE_W-1:0]   byteena = '0;
   logic [DATA_W-1:0] writeData = '0;
   logic              ready, rvalid, init_done, err;
   logic [DATA_W-1:0] readData;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [DATA_W-1:0] model [DEPTH];

   vram_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset(reset), .req(req), .ready(ready), .wren(wren),
      .address(address), .byteena(byteena), .writeData(writeData),
      .readData(readData), .rvalid(rvalid), .init_done(init_done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1);
   end

   function automatic logic [DATA_W-1:0] rand_word();
      logic [DATA_W-1:0] w;
      for (int i = 0; i < DATA_W / 32; i++) w[32*i +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [BE_W-1:0] rand_be();
      int sel = $urandom_range(0, 5);
      if (sel == 0) return '0;
      if (sel == 1) return '1;
      return $urandom;
   endfunction

   function automatic logic [DATA_W-1:0] model_read(int a);
      return (a < DEPTH) ? model[a] : '0;
   endfunction

   task automatic model_write(int a, logic [BE_W-1:0] be, logic [DATA_W-1:0] d);
      if (a < DEPTH)
         for (int i = 0; i < BE_W; i++)
            if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   // Present a request and hold it until accepted; returns the accept cycle
   task automatic issue(input bit w, input int a, input logic [BE_W-1:0] be,
                        input logic [DATA_W-1:0] d, output int acc, output bit to);
      int n = 0;
      to = 0;
      wren = w; address = ADDR_W'(a); byteena = be; writeData = d; req = 1'b1;
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready) to = 1;
      @(posedge clk);
      #1;
      acc = cyc;
      req = 1'b0;
      if (w && !to) model_write(a, be, d);
   endtask

   // Issue a read and watch for its response, one sample per negedge
   task automatic do_read(input int a, output int lat, output logic [DATA_W-1:0] d,
                          output bit e1, output int rdy_low, output bit rdy_rv, output bit to);
      int acc;
      bit ito;
      lat = 0; d = '0; e1 = 0; rdy_low = 0; rdy_rv = 0; to = 1;
      issue(0, a, '0, '0, acc, ito);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 1) e1 = err;
         if (rvalid) begin
            lat = k; d = readData; rdy_rv = ready; to = ito;
            break;
         end
         if (!ready) rdy_low++;
      end
   endtask

   task automatic test_reset();
      int n = 0;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || rvalid !== 1'b0 || init_done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl ready=%b rvalid=%b init_done=%b err=%b need 0000",
                  ready, rvalid, init_done, err);
      end
      checks++;
      if (readData !== '0) begin
         errors++;
         $display("FAIL reset_rdata got=%h need 0", readData);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      model_clear();
      @(negedge clk);
      while (!init_done && n < 300) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n !== DEPTH) begin
         errors++;
         $display("FAIL init_cycles got=%0d need %0d", n, DEPTH);
      end
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_init got=%b need 1", ready);
      end
   endtask

   task automatic test_init_zero();
      int lat, rl; logic [DATA_W-1:0] d; bit e1, rr, to;
      for (int a = 0; a < DEPTH; a++) begin
         do_read(a, lat, d, e1, rl, rr, to);
         checks++;
         if (to || lat !== RD_LAT || d !== '0 || e1 !== 1'b0) begin
            errors++;
            $display("FAIL init_zero a=%0d lat=%0d err=%b got=%h need lat %0d data 0",
                     a, lat, e1, d, RD_LAT);
         end
      end
   endtask

   task automatic test_partial_write();
      int acc, lat, rl; logic [DATA_W-1:0] d, wd, expv; bit e1, rr, to;
      for (int i = 0; i < BE_W; i++) wd[8*i +: 8] = 8'hAA;
      expv = {224'h0, 32'hAAAA_AAAA};
      issue(1, 5, 32'h0000_000F, wd, acc, to);
      do_read(5, lat, d, e1, rl, rr, to);
      checks++;
      if (to || d !== expv) begin
         errors++;
         $display("FAIL partial_write got=%h need %h", d, expv);
      end
   endtask

   task automatic test_raw();
      int acc_w, acc_r, lat, rl; logic [DATA_W-1:0] d, wd; logic [BE_W-1:0] be;
      bit e1, rr, to, to2;
      for (int t = 0; t < 4; t++) begin
         wd = rand_word();
         be = rand_be();
         issue(1, 7, be, wd, acc_w, to);
         acc_r = 0; lat = 0; rl = 0; rr = 0; d = '0; to2 = 1;
         issue(0, 7, '0, '0, acc_r, to2);
         for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (rvalid) begin
               lat = k; d = readData; rr = ready;
               break;
            end
            if (!ready) rl++;
         end
         checks++;
         if (to || to2 || acc_r !== acc_w + 1) begin
            errors++;
            $display("FAIL raw_accept write=%0d read=%0d need consecutive", acc_w, acc_r);
         end
         checks++;
         if (lat !== RD_LAT || rl !== RD_LAT - 1 || rr !== 1'b1) begin
            errors++;
            $display("FAIL raw_timing lat=%0d ready_low=%0d ready_at_rvalid=%b need %0d %0d 1",
                     lat, rl, rr, RD_LAT, RD_LAT - 1);
         end
         checks++;
         if (d !== model_read(7)) begin
            errors++;
            $display("FAIL raw_data got=%h need %h", d, model_read(7));
         end
      end
   endtask

   task automatic test_out_of_range();
      int acc, lat, rl; logic [DATA_W-1:0] d; bit e1, rr, to;
      int oob [4] = '{100, 69, 16325, 16383};
      do_read(64, lat, d, e1, rl, rr, to);
      checks++;
      if (to || lat !== RD_LAT || d !== '0 || e1 !== 1'b1) begin
         errors++;
         $display("FAIL oob_read lat=%0d err=%b got=%h need lat %0d err 1 data 0",
                  lat, e1, d, RD_LAT);
      end
      foreach (oob[j]) begin
         issue(1, oob[j], '1, rand_word(), acc, to);
         @(negedge clk);
         checks++;
         if (to || err !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL oob_write a=%0d err=%b rvalid=%b need err 1 rvalid 0",
                     oob[j], err, rvalid);
         end
      end
      for (int a = 0; a < DEPTH; a++) begin
         do_read(a, lat, d, e1, rl, rr, to);
         checks++;
         if (to || d !== model_read(a) || e1 !== 1'b0) begin
            errors++;
            $display("FAIL oob_readback a=%0d err=%b got=%h need %h", a, e1, d, model_read(a));
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc, prev, gaps, tos, lat, rl; logic [DATA_W-1:0] d; bit e1, rr, to;
      gaps = 0; tos = 0; prev = 0;
      for (int a = 0; a < DEPTH; a++) begin
         issue(1, a, (a % 2 == 0) ? '1 : rand_be(), rand_word(), acc, to);
         if (to) tos++;
         if (a > 0 && acc !== prev + 1) gaps++;
         prev = acc;
      end
      checks++;
      if (gaps !== 0 || tos !== 0) begin
         errors++;
         $display("FAIL b2b_stream gaps=%0d timeouts=%0d need 0 0", gaps, tos);
      end
      for (int a = 0; a < DEPTH; a++) begin
         do_read(a, lat, d, e1, rl, rr, to);
         checks++;
         if (to || lat !== RD_LAT || d !== model_read(a)) begin
            errors++;
            $display("FAIL b2b_readback a=%0d lat=%0d got=%h need %h", a, lat, d, model_read(a));
         end
      end
   endtask

   task automatic test_random();
      int a, acc, lat, rl; logic [DATA_W-1:0] d; bit e1, rr, to;
      for (int t = 0; t < 150; t++) begin
         a = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 16383) : $urandom_range(0, 79);
         if ($urandom_range(0, 1) == 1) begin
            issue(1, a, rand_be(), rand_word(), acc, to);
            @(negedge clk);
            checks++;
            if (to || err !== (a >= DEPTH) || rvalid !== 1'b0) begin
               errors++;
               $display("FAIL rand_write a=%0d err=%b rvalid=%b need err %b rvalid 0",
                        a, err, rvalid, a >= DEPTH);
            end
         end else begin
            do_read(a, lat, d, e1, rl, rr, to);
            checks++;
            if (to || lat !== RD_LAT || e1 !== (a >= DEPTH) || d !== model_read(a)) begin
               errors++;
               $display("FAIL rand_read a=%0d lat=%0d err=%b got=%h need %h",
                        a, lat, e1, d, model_read(a));
            end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      int acc, n, lat, rl; logic [DATA_W-1:0] d; bit e1, rr, to, rv_seen;
      issue(1, 3, '1, rand_word() | 256'h1, acc, to);
      issue(0, 3, '0, '0, acc, to);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b0 || init_done !== 1'b0 || rvalid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset ready=%b init_done=%b rvalid=%b need 000",
                  ready, init_done, rvalid);
      end
      rv_seen = 0;
      repeat (3) begin
         @(negedge clk);
         rv_seen |= rvalid;
      end
      @(posedge clk);
      #1 reset = 1'b0;
      model_clear();
      n = 0;
      @(negedge clk);
      rv_seen |= rvalid;
      while (!init_done && n < 300) begin
         n++;
         @(negedge clk);
         rv_seen |= rvalid;
      end
      checks++;
      if (rv_seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_read_rvalid got=%b need 0", rv_seen);
      end
      checks++;
      if (n !== DEPTH) begin
         errors++;
         $display("FAIL reinit_cycles got=%0d need %0d", n, DEPTH);
      end
      for (int a = 0; a < DEPTH; a += 3) begin
         do_read(a, lat, d, e1, rl, rr, to);
         checks++;
         if (to || lat !== RD_LAT || d !== '0) begin
            errors++;
            $display("FAIL reinit_zero a=%0d lat=%0d got=%h need 0", a, lat, d);
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_init_zero();
      test_partial_write();
      test_raw();
      test_out_of_range();
      test_back_to_back();
      test_random();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
